// File: rtl/chip8_pkg.sv
// Shared CHIP-8 definitions: VRAM geometry, scanout FSM encoding and pixel colour helper.
package chip8_pkg;

  localparam int ROWS   = 32;
  localparam int COLS   = 64;
  localparam int ADDR_W = 5;
  localparam int WORD_W = 64;
  localparam int RGB_W  = 16;

  localparam logic [ADDR_W-1:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [5:0]        LAST_COL = 6'(COLS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_EMIT  = 3'd4,
    ST_DONE  = 3'd5
  } scan_state_e;

  function automatic logic [RGB_W-1:0] pix_colour(input logic bit_val,
                                                  input logic [RGB_W-1:0] fg,
                                                  input logic [RGB_W-1:0] bg);
    return bit_val ? fg : bg;
  endfunction

endpackage

// File: rtl/chip8_vram_scanout_if.sv
// VRAM port B plus the RGB565 pixel stream towards the LCD driver.
interface chip8_vram_scanout_if;

  logic [chip8_pkg::ADDR_W-1:0] vram_address_b;
  logic [chip8_pkg::WORD_W-1:0] vram_data_out_b;
  logic                         vram_wren_b;
  logic [chip8_pkg::WORD_W-1:0] vram_data_in_b;
  logic [chip8_pkg::RGB_W-1:0]  pix_rgb;
  logic                         pix_valid;
  logic                         pix_ready;

  modport master (
    output vram_address_b, vram_wren_b, vram_data_in_b, pix_rgb, pix_valid,
    input  vram_data_out_b, pix_ready
  );

  modport slave (
    input  vram_address_b, vram_wren_b, vram_data_in_b, pix_rgb, pix_valid,
    output vram_data_out_b, pix_ready
  );

endinterface

// File: rtl/chip8_vram_scanout.sv
// Walks the 32x64 framebuffer once per frame_start and streams RGB565 pixels,
// replicating each bit SCALE times across and each row SCALE times down.
module chip8_vram_scanout
  import chip8_pkg::*;
#(
  parameter int                SCALE  = 1,
  parameter logic [RGB_W-1:0]  FG_RGB = 16'hFFFF,
  parameter logic [RGB_W-1:0]  BG_RGB = 16'h0000
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic                frame_start,
  output logic                busy,
  output logic                frame_done,
  chip8_vram_scanout_if.master bus
);

  localparam logic [1:0] SCALE_M1 = 2'(SCALE - 1);

  scan_state_e        state_r;
  logic [ADDR_W-1:0]  row_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [5:0]         col_r;
  logic [1:0]         hrep_r;
  logic [1:0]         vrep_r;
  logic [WORD_W-1:0]  shift_r;
  logic [RGB_W-1:0]   rgb_r;
  logic               valid_r;
  logic               busy_r;
  logic               done_r;

  logic               xfer_s;
  logic               pix_last_s;

  assign xfer_s     = valid_r & bus.pix_ready;
  assign pix_last_s = (hrep_r == SCALE_M1);

  // Scanout FSM with counters, row shift register and all registered outputs
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      row_r   <= 5'd0;
      addr_r  <= 5'd0;
      col_r   <= 6'd0;
      hrep_r  <= 2'd0;
      vrep_r  <= 2'd0;
      shift_r <= 64'd0;
      rgb_r   <= 16'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (frame_start) begin
            row_r   <= 5'd0;
            vrep_r  <= 2'd0;
            addr_r  <= 5'd0;
            busy_r  <= 1'b1;
            state_r <= ST_FETCH;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FETCH: state_r <= ST_WAIT;
        ST_WAIT:  state_r <= ST_LOAD;
        ST_LOAD: begin
          shift_r <= bus.vram_data_out_b;
          col_r   <= 6'd0;
          hrep_r  <= 2'd0;
          rgb_r   <= pix_colour(bus.vram_data_out_b[WORD_W-1], FG_RGB, BG_RGB);
          valid_r <= 1'b1;
          state_r <= ST_EMIT;
        end
        ST_EMIT: begin
          if (!xfer_s) begin
            state_r <= ST_EMIT;
          end else if (!pix_last_s) begin
            hrep_r <= hrep_r + 2'd1;
          end else if (col_r != LAST_COL) begin
            // Next pixel's colour comes from the bit about to reach the MSB
            hrep_r  <= 2'd0;
            col_r   <= col_r + 6'd1;
            shift_r <= shift_r << 1;
            rgb_r   <= pix_colour(shift_r[WORD_W-2], FG_RGB, BG_RGB);
          end else begin
            valid_r <= 1'b0;
            hrep_r  <= 2'd0;
            if (vrep_r != SCALE_M1) begin
              vrep_r  <= vrep_r + 2'd1;
              state_r <= ST_FETCH;
            end else if (row_r != LAST_ROW) begin
              row_r   <= row_r + 5'd1;
              addr_r  <= row_r + 5'd1;
              vrep_r  <= 2'd0;
              state_r <= ST_FETCH;
            end else begin
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.vram_address_b = addr_r;
  assign bus.vram_wren_b    = 1'b0;
  assign bus.vram_data_in_b = 64'd0;
  assign bus.pix_rgb        = rgb_r;
  assign bus.pix_valid      = valid_r;
  assign busy               = busy_r;
  assign frame_done         = done_r;

endmodule

// File: tb/tb_chip8_vram_scanout.sv
// Self-checking bench: SCALE=1 and SCALE=2 instances, 2-cycle VRAM model,
// randomized backpressure checked against an arithmetic raster model.
module tb_chip8_vram_scanout;

  logic clk;
  logic reset_n;
  logic fs1, fs2;
  logic busy1, busy2, done1, done2;
  logic [63:0] mem [32];
  logic [4:0]  aq1, aq2;
  int checks = 0;
  int errors = 0;

  chip8_vram_scanout_if bus1 ();
  chip8_vram_scanout_if bus2 ();

  chip8_vram_scanout #(.SCALE(1)) dut1 (
    .CLOCK_50(clk), .reset_n(reset_n), .frame_start(fs1),
    .busy(busy1), .frame_done(done1), .bus(bus1.master));

  chip8_vram_scanout #(.SCALE(2)) dut2 (
    .CLOCK_50(clk), .reset_n(reset_n), .frame_start(fs2),
    .busy(busy2), .frame_done(done2), .bus(bus2.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM port B: address registered on one edge, data out on the next
  always @(posedge clk) begin
    aq1 <= bus1.vram_address_b;
    aq2 <= bus2.vram_address_b;
    bus1.vram_data_out_b <= mem[aq1];
    bus2.vram_data_out_b <= mem[aq2];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output pixel n of a frame scaled by s, straight from the raster definition
  function automatic logic [15:0] exp_pix(input int s, input int n);
    int w, oy, ox;
    logic [63:0] word;
    w = 64 * s;
    oy = n / w;
    ox = n % w;
    word = mem[oy / s];
    return word[63 - ox / s] ? 16'hFFFF : 16'h0000;
  endfunction

  task automatic sample(input int sel, output bit v, output logic [15:0] rgb,
                        output bit fd, output bit bz, output logic [4:0] addr,
                        output bit wr, output logic [63:0] din);
    if (sel == 1) begin
      v = bus1.pix_valid; rgb = bus1.pix_rgb; fd = done1; bz = busy1;
      addr = bus1.vram_address_b; wr = bus1.vram_wren_b; din = bus1.vram_data_in_b;
    end else begin
      v = bus2.pix_valid; rgb = bus2.pix_rgb; fd = done2; bz = busy2;
      addr = bus2.vram_address_b; wr = bus2.vram_wren_b; din = bus2.vram_data_in_b;
    end
  endtask

  task automatic set_start(input int sel, input logic val);
    if (sel == 1) fs1 = val;
    else fs2 = val;
  endtask

  task automatic set_ready(input int sel, input logic val);
    if (sel == 1) bus1.pix_ready = val;
    else bus2.pix_ready = val;
  endtask

  task automatic run_frame(input int sel, input bit rand_rdy, input int abort_at,
                           input bit pulse_mid, input bit hold, input int exp_cycles);
    int s, cyc, ntr, first_v, done_cyc;
    bit fin, pv, pr, v, fd, bz, wr, rd;
    logic [15:0] prgb, rgb;
    logic [4:0] addr;
    logic [63:0] din;
    s = (sel == 1) ? 1 : 2;
    cyc = 0; ntr = 0; first_v = -1; done_cyc = -1;
    fin = 1'b0; pv = 1'b0; pr = 1'b0; prgb = 16'h0000;
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    while (!fin && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && !hold) set_start(sel, 1'b0);
      if (pulse_mid && cyc == 700) set_start(sel, 1'b1);
      if (pulse_mid && cyc == 701) set_start(sel, 1'b0);
      sample(sel, v, rgb, fd, bz, addr, wr, din);
      if (cyc == 1) check("busy_after_accept", 64'(bz), 64'd1);
      check("wren_b", 64'(wr), 64'd0);
      check("data_in_b", din, 64'd0);
      if (pv && !pr) begin
        check("stall_valid", 64'(v), 64'd1);
        check("stall_rgb", 64'(rgb), 64'(prgb));
      end
      if (v && first_v < 0) first_v = cyc;
      if (abort_at > 0 && ntr == abort_at) begin
        reset_n = 1'b0;
        #1;
        sample(sel, v, rgb, fd, bz, addr, wr, din);
        check("abort_valid", 64'(v), 64'd0);
        check("abort_busy", 64'(bz), 64'd0);
        check("abort_rgb", 64'(rgb), 64'd0);
        check("abort_addr", 64'(addr), 64'd0);
        set_start(sel, 1'b0);
        repeat (3) begin
          @(negedge clk);
          sample(sel, v, rgb, fd, bz, addr, wr, din);
          check("abort_no_done", 64'(fd), 64'd0);
        end
        reset_n = 1'b1;
        set_ready(sel, 1'b1);
        @(negedge clk);
        sample(sel, v, rgb, fd, bz, addr, wr, din);
        check("after_abort_done", 64'(fd), 64'd0);
        return;
      end
      if (fd) begin
        fin = 1'b1;
        done_cyc = cyc;
      end
      rd = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      set_ready(sel, rd);
      if (v && rd) begin
        check("pixel", 64'(rgb), 64'(exp_pix(s, ntr)));
        check("vram_address", 64'(addr), 64'((ntr / (64 * s)) / s));
        ntr++;
      end
      pv = v; pr = rd; prgb = rgb;
    end
    check("frame_completed", 64'(fin), 64'd1);
    check("transfers", 64'(ntr), 64'(2048 * s * s));
    check("first_valid_cycle", 64'(first_v), 64'd4);
    if (exp_cycles > 0) check("done_cycle", 64'(done_cyc), 64'(exp_cycles));
    @(negedge clk);
    sample(sel, v, rgb, fd, bz, addr, wr, din);
    check("done_one_cycle", 64'(fd), 64'd0);
    check("busy_after_done", 64'(bz), 64'd0);
    if (hold) begin
      @(negedge clk);
      sample(sel, v, rgb, fd, bz, addr, wr, din);
      check("held_start_reaccept", 64'(bz), 64'd1);
      set_start(sel, 1'b0);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
    end else begin
      repeat (5) @(negedge clk);
      sample(sel, v, rgb, fd, bz, addr, wr, din);
      check("start_not_queued", 64'(bz), 64'd0);
      check("no_second_done", 64'(fd), 64'd0);
    end
    set_ready(sel, 1'b1);
  endtask

  task automatic fill_random();
    for (int r = 0; r < 32; r++) mem[r] = {$urandom, $urandom};
  endtask

  task automatic fill_zero();
    for (int r = 0; r < 32; r++) mem[r] = 64'd0;
  endtask

  initial begin
    reset_n = 1'b0;
    fs1 = 1'b0;
    fs2 = 1'b0;
    bus1.pix_ready = 1'b1;
    bus2.pix_ready = 1'b1;
    fill_zero();
    repeat (3) @(negedge clk);
    check("rst_valid1", 64'(bus1.pix_valid), 64'd0);
    check("rst_busy1", 64'(busy1), 64'd0);
    check("rst_done1", 64'(done1), 64'd0);
    check("rst_rgb1", 64'(bus1.pix_rgb), 64'd0);
    check("rst_addr1", 64'(bus1.vram_address_b), 64'd0);
    check("rst_valid2", 64'(bus2.pix_valid), 64'd0);
    check("rst_busy2", 64'(busy2), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Abort mid-frame, then a clean frame that must start again at row 0
    fill_random();
    run_frame(1, 1'b1, 100, 1'b0, 1'b0, 0);
    run_frame(1, 1'b1, 0, 1'b0, 1'b0, 0);

    // Corner pixels of row 0 at SCALE=1, exact frame length
    fill_zero();
    mem[0] = 64'h8000_0000_0000_0001;
    run_frame(1, 1'b0, 0, 1'b0, 1'b0, 2145);

    // Row 5 left pair at SCALE=2, exact frame length
    fill_zero();
    mem[5] = 64'hC000_0000_0000_0000;
    run_frame(2, 1'b0, 0, 1'b0, 1'b0, 8385);

    // Random backpressure at SCALE=2 with a frame_start pulse mid-scan
    fill_random();
    run_frame(2, 1'b1, 0, 1'b1, 1'b0, 0);

    // frame_start held high across the end of a frame
    fill_random();
    run_frame(1, 1'b0, 0, 1'b0, 1'b1, 2145);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip8_vram_scanout.md
# chip8_vram_scanout

Display-side consumer of the CHIP-8 VRAM (32 rows × 64-bit words, dual-port). It owns VRAM port B read-only and walks the framebuffer once per `frame_start` request. It emits an RGB565 pixel stream with a valid/ready handshake to the LCD driver (vma412-class panel), with optional integer up-scaling. The CPU keeps exclusive use of port A; this block never writes VRAM.

## Interface
Parameters:
- `SCALE`, 1: integer pixel replication factor, applied horizontally and vertically; legal range 1–4.
- `FG_RGB`, 16'hFFFF: RGB565 colour for a set pixel.
- `BG_RGB`, 16'h0000: RGB565 colour for a clear pixel.

Ports:
- `CLOCK_50` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: start one frame scan; sampled only in IDLE.
- `vram_address_b` out 5: VRAM port B row address.
- `vram_data_out_b` in 64: VRAM port B read data. Valid on the second rising edge after the address is driven.
- `vram_wren_b` out 1: constant 0.
- `vram_data_in_b` out 64: constant 0.
- `pix_rgb` out 16: pixel colour.
- `pix_valid` out 1: `pix_rgb` is valid.
- `pix_ready` in 1: sink accepts the pixel; a transfer occurs on an edge where valid and ready are both 1.
- `busy` out 1: high from frame accept until `frame_done`.
- `frame_done` out 1: one-cycle pulse after the final pixel transfer.

## Operation
- Pixel order: raster scan, rows 0..31 top to bottom. Within a row, bit 63 is x=0 (leftmost) and bit 0 is x=63. This matches CHIP-8 MSB-first sprites.
- Colour: the pixel bit selects `FG_RGB` when 1 and `BG_RGB` when 0.
- Output size: each source row is output SCALE times. Each bit within a row is output SCALE times. Output frame is (64·SCALE) × (32·SCALE).
- FSM states:
  - IDLE: waits for `frame_start`. On accept, set row=0, vrep=0, drive `vram_address_b`=row, go to FETCH.
  - FETCH: 1 cycle, address registered in RAM. Go to WAIT.
  - WAIT: 1 cycle. Go to LOAD.
  - LOAD: capture `vram_data_out_b` into a 64-bit shift register; set col=0, hrep=0. Go to EMIT.
  - EMIT: assert `pix_valid`. On each transfer:
    - increment hrep;
    - when hrep==SCALE−1, shift left one bit, clear hrep, increment col.
    - After the last transfer of the row (col==63, hrep==SCALE−1):
      - if vrep<SCALE−1: increment vrep, re-read the same row, go to FETCH;
      - else if row<31: increment row, clear vrep, go to FETCH;
      - else go to DONE.
  - DONE: 1 cycle, `frame_done`=1. Go to IDLE.
- Handshake: while `pix_valid`=1 and `pix_ready`=0, `pix_rgb` holds stable and no state advances. `pix_valid` never drops without a transfer.
- Counters: row is 5 bits, col 6 bits, hrep/vrep 2 bits. The last row/column is detected explicitly, not by wrap-around.
- `frame_start` while `busy`=1: ignored, not queued.
- `frame_start` held high: a new frame starts on the edge following DONE, because IDLE samples it.
- VRAM written by the CPU mid-scan: rows already latched keep their old content; later rows show the new content. This tearing is accepted.
- Reset mid-frame: immediately returns to IDLE; the current frame is abandoned with no `frame_done`.
- Reset values: IDLE; `pix_valid`=0, `busy`=0, `frame_done`=0, `pix_rgb`=0, `vram_address_b`=0.

## Timing
- Accept edge E (IDLE, `frame_start`=1): `busy`=1 after E. FETCH occupies E+1, WAIT E+2, LOAD E+3.
- First `pix_valid`=1 appears after edge E+3, i.e. 3 cycles after accept.
- Row turnaround: 3 idle cycles (FETCH, WAIT, LOAD) between the last transfer of a row and the next `pix_valid`. There is no prefetch.
- With `pix_ready` tied 1, accept-to-`frame_done` = 32·SCALE·(64·SCALE + 3) + 1 cycles. That is 2145 cycles for SCALE=1.
- `busy` falls on the same edge that `frame_done` falls.

## Structure
- Shared package `chip8_pkg`:
  - VRAM geometry constants: ROWS=32, COLS=64, address width 5, word width 64.
  - Scanout FSM state encoding.
  - RGB565 width constant.
- No sub-module. The FSM, counters and 64-bit shift register are implemented in this block.

## Test plan
- Reset mid-EMIT (assert `reset_n`=0 at pixel 100) → outputs return to reset values asynchronously; no `frame_done`; next `frame_start` scans from row 0.
- SCALE=1, `pix_ready`=1, row 0 = 64'h8000_0000_0000_0001, other rows 0 → pixel 0 = FFFF, pixel 63 = FFFF, pixels 1..62 and all others = 0000; `frame_done` exactly 2145 cycles after accept.
- SCALE=2, row 5 = 64'hC000_0000_0000_0000 → output row 10 and row 11 each have pixels 0..3 = FFFF and pixels 4..127 = 0000; 128·64 transfers total.
- Random `pix_ready` (50% duty) → `pix_rgb` is stable through every stall; the transferred stream equals the golden model; no transfer is lost or duplicated.
- `frame_start` pulsed during a scan → ignored, only one `frame_done`. `frame_start` held high → the second frame's accept occurs on the edge after DONE.
- `vram_wren_b`/`vram_data_in_b` stay 0 throughout. `vram_address_b` sequence with SCALE=1 is 0,1,...,31, each held from FETCH until the next FETCH.
